// File: rtl/divisor_iterativo.sv
// Iterative restoring divider: one quotient bit per clock, signed or unsigned,
// fixed latency of tamanyo+2 cycles from the accepting edge to Done.
module divisor_iterativo #(
  parameter int tamanyo = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               Start,
  input  logic               Signo,
  input  logic [tamanyo-1:0] Num,
  input  logic [tamanyo-1:0] Den,
  output logic [tamanyo-1:0] Coc,
  output logic [tamanyo-1:0] Res,
  output logic               Done,
  output logic               Busy,
  output logic               DivZero
);

  localparam int            CW     = $clog2(tamanyo);
  localparam logic [CW-1:0] ULTIMA = CW'(tamanyo - 1);

  typedef enum logic [1:0] {IDLE, OP, FIX, FIN} estado_t;

  estado_t            estado, estado_sig;
  logic [CW-1:0]      cuenta;
  logic [tamanyo-1:0] resto;
  logic [tamanyo-1:0] cociente;
  logic [tamanyo-1:0] divisor;
  logic               neg_num, neg_den, den_cero;

  logic [tamanyo:0]   resto_desp;
  logic [tamanyo-1:0] resto_resta;
  logic               bit_coc;
  logic [tamanyo-1:0] coc_fix, res_fix;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, regardless of the order the always blocks are evaluated.
  always_ff @(posedge CLK) begin
    if (RST) estado <= IDLE;
    else     estado <= estado_sig;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    estado_sig = estado;
    Done       = 1'b0;
    Busy       = 1'b1;
    case (estado)
      IDLE: begin
        Busy = 1'b0;
        if (Start) estado_sig = OP;
      end
      OP:      if (cuenta == ULTIMA) estado_sig = FIX;
      FIX:     estado_sig = FIN;
      FIN: begin
        Done       = 1'b1;
        estado_sig = IDLE;
      end
      default: estado_sig = IDLE;
    endcase
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The difference only needs the low bits, since a kept result is below divisor.
  always_comb begin
    resto_desp  = {resto, cociente[tamanyo-1]};
    resto_resta = resto_desp[tamanyo-1:0] - divisor;
    bit_coc     = (resto_desp >= {1'b0, divisor});
  end

  // Sign fix-up on magnitudes; a zero divisor forces the all-ones quotient,
  // while the remainder already equals the captured dividend.
  always_comb begin
    coc_fix = (neg_num ^ neg_den) ? -cociente : cociente;
    if (den_cero) coc_fix = '1;
    res_fix = neg_num ? -resto : resto;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cuenta   <= '0;
      resto    <= '0;
      cociente <= '0;
      divisor  <= '0;
      neg_num  <= 1'b0;
      neg_den  <= 1'b0;
      den_cero <= 1'b0;
      Coc      <= '0;
      Res      <= '0;
      DivZero  <= 1'b0;
    end else begin
      case (estado)
        IDLE: if (Start) begin
          neg_num  <= Signo & Num[tamanyo-1];
          neg_den  <= Signo & Den[tamanyo-1];
          cociente <= (Signo && Num[tamanyo-1]) ? -Num : Num;
          divisor  <= (Signo && Den[tamanyo-1]) ? -Den : Den;
          den_cero <= (Den == '0);
          resto    <= '0;
          cuenta   <= '0;
        end
        OP: begin
          resto    <= bit_coc ? resto_resta : resto_desp[tamanyo-1:0];
          cociente <= {cociente[tamanyo-2:0], bit_coc};
          cuenta   <= cuenta + 1'b1;
        end
        FIX: begin
          Coc     <= coc_fix;
          Res     <= res_fix;
          DivZero <= den_cero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_iterativo.sv
// Self-checking bench for divisor_iterativo (tamanyo=16): cycle-level model built
// from plain arithmetic and acceptance timing, plus literal expectations.
module tb_divisor_iterativo;

  localparam int W   = 16;
  localparam int LAT = W + 2;

  logic         CLK = 1'b0;
  logic         RST, Start, Signo;
  logic [W-1:0] Num, Den, Coc, Res;
  logic         Done, Busy, DivZero;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  divisor_iterativo #(.tamanyo(W)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Signo(Signo), .Num(Num), .Den(Den),
    .Coc(Coc), .Res(Res), .Done(Done), .Busy(Busy), .DivZero(DivZero)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference result straight from the arithmetic definition.
  function automatic void ref_div(input logic s, input logic [W-1:0] n, input logic [W-1:0] d,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    int ni, di;
    if (d == '0) begin
      q = '1; r = n; dz = 1'b1;
    end else begin
      dz = 1'b0;
      if (s) begin
        ni = int'($signed(n));
        di = int'($signed(d));
        q  = W'(ni / di);
        r  = W'(ni % di);
      end else begin
        q = n / d;
        r = n % d;
      end
    end
  endfunction

  // Model: an operation accepted at edge E0 updates results and pulses Done
  // after edge E0+LAT-1, keeps Busy through that window, and the next request
  // can be accepted no earlier than edge E0+LAT+1.
  int           cyc        = 0;
  int           next_ok    = 0;
  int           done_at    = -1;
  int           busy_until = -1;
  bit           model_on   = 1'b0;
  logic [W-1:0] m_coc, m_res, p_coc, p_res;
  logic         m_dz, p_dz;

  always @(posedge CLK) begin
    cyc++;
    if (RST) begin
      model_on   = 1'b1;
      m_coc      = '0;
      m_res      = '0;
      m_dz       = 1'b0;
      done_at    = -1;
      busy_until = -1;
      next_ok    = cyc + 1;
    end else if (model_on) begin
      if (cyc == done_at) begin
        m_coc = p_coc;
        m_res = p_res;
        m_dz  = p_dz;
      end
      if (cyc >= next_ok && Start) begin
        ref_div(Signo, Num, Den, p_coc, p_res, p_dz);
        done_at    = cyc + LAT - 1;
        busy_until = cyc + LAT - 1;
        next_ok    = cyc + LAT + 1;
      end
    end
  end

  always @(negedge CLK) begin
    if (model_on) begin
      check("model_done",    Done,    cyc == done_at);
      check("model_busy",    Busy,    cyc <= busy_until);
      check("model_coc",     Coc,     m_coc);
      check("model_res",     Res,     m_res);
      check("model_divzero", DivZero, m_dz);
    end
  end

  // Called at a negedge; holds Start until accepted, then scrambles the inputs.
  task automatic do_op(input logic s, input logic [W-1:0] n, input logic [W-1:0] d,
                       input logic [W-1:0] ec, input logic [W-1:0] er, input logic edz,
                       input string tag);
    int k;
    Signo = s; Num = n; Den = d; Start = 1'b1;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!Busy && k < 40);
    check({tag, "_accept"}, Busy, 1'b1);
    Start = 1'b0;
    if (!Busy) return;
    Num   = W'($urandom);
    Den   = W'($urandom);
    Signo = 1'($urandom);
    k = 1;
    while (!Done && k < 40) begin
      @(negedge CLK);
      k++;
    end
    check({tag, "_latency"}, k,       LAT);
    check({tag, "_coc"},     Coc,     ec);
    check({tag, "_res"},     Res,     er);
    check({tag, "_divzero"}, DivZero, edz);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      3:       return 16'h0001;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1);
  end

  initial begin
    int dones;
    int k;
    RST = 1'b1; Start = 1'b0; Signo = 1'b0; Num = '0; Den = '0;
    repeat (2) @(negedge CLK);
    check("rst_coc",     Coc,     16'h0);
    check("rst_res",     Res,     16'h0);
    check("rst_done",    Done,    1'b0);
    check("rst_busy",    Busy,    1'b0);
    check("rst_divzero", DivZero, 1'b0);
    RST = 1'b0;

    do_op(1'b0, 16'd100,  16'd7,     16'd14,    16'd2,    1'b0, "u100_7");
    do_op(1'b1, 16'hFFF9, 16'd2,     16'hFFFD,  16'hFFFF, 1'b0, "s_m7_2");
    do_op(1'b0, 16'hFFF9, 16'd2,     16'h7FFC,  16'd1,    1'b0, "u_fff9_2");
    do_op(1'b0, 16'h1234, 16'h0,     16'hFFFF,  16'h1234, 1'b1, "u_div0");
    do_op(1'b1, 16'h1234, 16'h0,     16'hFFFF,  16'h1234, 1'b1, "s_div0");
    do_op(1'b1, 16'h8005, 16'h0,     16'hFFFF,  16'h8005, 1'b1, "s_neg_div0");
    do_op(1'b1, 16'h8000, 16'hFFFF,  16'h8000,  16'h0,    1'b0, "s_overflow");
    do_op(1'b1, 16'd100,  16'hFFF9,  16'hFFF2,  16'd2,    1'b0, "s_100_m7");

    // Abort mid-operation: outputs clear, no Done, next request runs normally.
    Signo = 1'b0; Num = 16'd1000; Den = 16'd3; Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("abort_coc",     Coc,     16'h0);
    check("abort_res",     Res,     16'h0);
    check("abort_done",    Done,    1'b0);
    check("abort_busy",    Busy,    1'b0);
    check("abort_divzero", DivZero, 1'b0);
    do_op(1'b0, 16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, "after_abort");

    // Start held high with changing operands: one result per LAT+1 cycles.
    k = 0;
    while (Busy && k < 40) begin
      @(negedge CLK);
      k++;
    end
    dones = 0;
    Start = 1'b1; Signo = 1'($urandom); Num = pick(); Den = pick();
    for (int i = 0; i < 5 * (LAT + 1); i++) begin
      @(negedge CLK);
      if (Done) dones++;
      Signo = 1'($urandom); Num = pick(); Den = pick();
    end
    Start = 1'b0;
    check("held_start_dones", dones, 5);

    // Random traffic with occasional resets; the model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      Start = ($urandom_range(0, 3) == 0);
      Signo = 1'($urandom);
      Num   = pick();
      Den   = pick();
      RST   = ($urandom_range(0, 299) == 0);
    end
    @(negedge CLK);
    RST = 1'b0; Start = 1'b0;
    repeat (LAT + 5) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
